// File: rtl/io_timer_pkg.sv
// io_timer_pkg: register offsets, CTRL/STATUS bit positions and interrupt FSM encodings for io_intr_timer.
package io_timer_pkg;
  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_LOAD   = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_PRE    = 3'd4;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;
  localparam int STAT_EXP  = 0;
  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_ACK  = 2'd2
  } irq_state_e;
endpackage

// File: rtl/io_irq_handshake.sv
// io_irq_handshake: intr request/acknowledge FSM with a one-deep pending flag for events arriving mid-handshake.
module io_irq_handshake
  import io_timer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic evt_i,
  input  logic inta_i,
  output logic intr_o
);
  irq_state_e state_q, state_d;
  logic pend_q, pend_d;
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      IRQ_IDLE: begin
        state_d = (evt_i || pend_q) ? IRQ_REQ : IRQ_IDLE;
        pend_d  = 1'b0;
      end
      IRQ_REQ: begin
        state_d = inta_i ? IRQ_ACK : IRQ_REQ;
        pend_d  = pend_q | evt_i;
      end
      IRQ_ACK: begin
        state_d = inta_i ? IRQ_ACK : IRQ_IDLE;
        pend_d  = pend_q | evt_i;
      end
      default: begin
        state_d = IRQ_IDLE;
        pend_d  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IRQ_IDLE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  assign intr_o = (state_q == IRQ_REQ);
endmodule

// File: rtl/io_intr_timer.sv
// io_intr_timer: memory-mapped down-counter timer with auto-reload and interrupt handshake.
// Optional 8-bit tick prescaler at offset 0x10 enabled by macro IO_TIMER_PRESCALE_EN.
module io_intr_timer
  import io_timer_pkg::*;
#(
  parameter logic [31:0] DEF_LOAD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_cs,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [31:0] io_address,
  input  logic [31:0] io_d_in,
  output logic [31:0] io_out,
  output logic        intr,
  input  logic        inta
);
  logic [2:0]  idx;
  logic        acc_wr, wr_ctrl, wr_load, wr_status, wr_pre;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] load_q, load_d, count_q, count_d, rd_val, pre_rd;
  logic        exp_q, exp_d, tick, expiry;
  logic        unused_addr;
  assign idx         = io_address[4:2];
  assign unused_addr = ^{io_address[31:5], io_address[1:0]};
  assign acc_wr      = io_cs & io_wr;
  assign wr_ctrl     = acc_wr && idx == OFF_CTRL;
  assign wr_load     = acc_wr && idx == OFF_LOAD;
  assign wr_status   = acc_wr && idx == OFF_STATUS;
  assign wr_pre      = acc_wr && idx == OFF_PRE;
`ifdef IO_TIMER_PRESCALE_EN
  logic [7:0] pre_q, pre_d, pcnt_q, pcnt_d;
  always_comb begin
    pre_d  = wr_pre ? io_d_in[7:0] : pre_q;
    pcnt_d = (wr_pre || wr_ctrl || !ctrl_q[CTRL_EN] || pcnt_q == pre_q) ? 8'h0 : pcnt_q + 8'h1;
    tick   = ctrl_q[CTRL_EN] && pcnt_q == pre_q;
    pre_rd = (idx == OFF_PRE) ? {24'h0, pre_q} : 32'h0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pre_q  <= 8'h0;
      pcnt_q <= 8'h0;
    end else begin
      pre_q  <= pre_d;
      pcnt_q <= pcnt_d;
    end
`else
  logic unused_pre;
  assign unused_pre = wr_pre;
  assign tick       = ctrl_q[CTRL_EN];
  assign pre_rd     = 32'h0;
`endif
  // A LOAD write overrides the counter that cycle, so it also suppresses expiry.
  always_comb begin
    expiry  = tick && count_q == 32'd1 && !wr_load;
    ctrl_d  = wr_ctrl ? io_d_in[2:0] : ctrl_q;
    load_d  = wr_load ? io_d_in : load_q;
    count_d = wr_load ? io_d_in :
              !tick ? count_q :
              (count_q != 32'd0) ? count_q - 32'd1 :
              ctrl_q[CTRL_AUTO] ? load_q : count_q;
    exp_d   = expiry | (exp_q & ~(wr_status & io_d_in[STAT_EXP]));
    rd_val  = (idx == OFF_CTRL)   ? {29'h0, ctrl_q} :
              (idx == OFF_LOAD)   ? load_q :
              (idx == OFF_COUNT)  ? count_q :
              (idx == OFF_STATUS) ? {31'h0, exp_q} : pre_rd;
    io_out  = (io_cs && io_rd) ? rd_val : 32'h0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ctrl_q  <= 3'h0;
      load_q  <= DEF_LOAD;
      count_q <= DEF_LOAD;
      exp_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      exp_q   <= exp_d;
    end
  io_irq_handshake u_irq (
    .clk    (clk),
    .reset  (reset),
    .evt_i  (expiry & ctrl_q[CTRL_IE]),
    .inta_i (inta),
    .intr_o (intr)
  );
endmodule

// File: tb/tb_io_intr_timer.sv
// tb_io_intr_timer: directed register-table and handshake sequences for io_intr_timer.
module tb_io_intr_timer;
  logic        clk = 1'b0, reset = 1'b0, io_cs = 1'b0, io_rd = 1'b0, io_wr = 1'b0, inta = 1'b0;
  logic [31:0] io_address = 32'h0, io_d_in = 32'h0, io_out;
  logic        intr;
  int          checks = 0, errors = 0;
  typedef struct {
    logic        cs, rd, wr;
    logic [31:0] a, d, e;
  } vec_t;
  vec_t tbl[24];
`ifdef IO_TIMER_PRESCALE_EN
  localparam logic [31:0] PRE_RB = 32'h0000_00FF;
`else
  localparam logic [31:0] PRE_RB = 32'h0;
`endif
  io_intr_timer dut (
    .clk        (clk),
    .reset      (reset),
    .io_cs      (io_cs),
    .io_rd      (io_rd),
    .io_wr      (io_wr),
    .io_address (io_address),
    .io_d_in    (io_d_in),
    .io_out     (io_out),
    .intr       (intr),
    .inta       (inta)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask
  task automatic chk_intr(input string n, input logic e);
    chk(n, {31'h0, intr}, {31'h0, e});
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic cs, input logic rd, input logic wr, input logic [31:0] a,
                    input logic [31:0] d, input logic [31:0] e, input string n);
    io_cs = cs; io_rd = rd; io_wr = wr; io_address = a; io_d_in = d;
    #1;
    chk(n, io_out, e);
    step();
    io_cs = 1'b0; io_rd = 1'b0; io_wr = 1'b0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    op(1'b1, 1'b0, 1'b1, a, d, 32'h0, "wr_out");
  endtask
  task automatic peek(input logic [31:0] a, input logic [31:0] e, input string n);
    io_cs = 1'b1; io_rd = 1'b1; io_address = a;
    #1;
    chk(n, io_out, e);
    io_cs = 1'b0; io_rd = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h00, 32'h0,         32'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h04, 32'h0,         32'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h08, 32'h0,         32'h0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0C, 32'h0,         32'h0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h0,         32'h0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'h00, 32'hFFFF_FFFA, 32'h0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h00, 32'h0,         32'h2};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h04, 32'hDEAD,      32'h0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h04, 32'h0,         32'h0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'h04, 32'h1234,      32'h0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h08, 32'h0,         32'h1234};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h04, 32'h5678,      32'h1234};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h04, 32'h0,         32'h5678};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 32'h08, 32'h0,         32'h5678};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 32'h10, 32'hFF,        32'h0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h0,         PRE_RB};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 32'h1C, 32'hFFFF,      32'h0};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 32'h1C, 32'h0,         32'h0};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 32'h24, 32'h0,         32'h5678};
    tbl[19] = '{1'b1, 1'b0, 1'b1, 32'h08, 32'h9999,      32'h0};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 32'h08, 32'h0,         32'h5678};
    tbl[21] = '{1'b1, 1'b0, 1'b1, 32'h0C, 32'hFFFF_FFFF, 32'h0};
    tbl[22] = '{1'b1, 1'b1, 1'b0, 32'h0C, 32'h0,         32'h0};
    tbl[23] = '{1'b1, 1'b1, 1'b0, 32'h00, 32'h0,         32'h2};
    #1;
    chk_intr("intr_in_reset", 1'b0);
    do_reset();
    chk_intr("intr_after_reset", 1'b0);
    for (int i = 0; i < 24; i++)
      op(tbl[i].cs, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].e, $sformatf("vec%0d", i));
    // Basic one-shot countdown and full handshake.
    do_reset();
    wr(32'h04, 32'd3);
    wr(32'h00, 32'h5);
    peek(32'h08, 32'd3, "A_cnt3");
    step(); peek(32'h08, 32'd2, "A_cnt2");
    step(); peek(32'h08, 32'd1, "A_cnt1"); chk_intr("A_intr_pre", 1'b0);
    step(); peek(32'h08, 32'd0, "A_cnt0"); peek(32'h0C, 32'd1, "A_exp"); chk_intr("A_intr", 1'b1);
    inta = 1'b1;
    step(); chk_intr("A_ack1", 1'b0);
    step(); chk_intr("A_ack2", 1'b0);
    inta = 1'b0;
    step(); chk_intr("A_idle", 1'b0);
    inta = 1'b1;
    step(); step(); chk_intr("A_inta_idle", 1'b0);
    inta = 1'b0;
    peek(32'h08, 32'd0, "A_hold0");
    wr(32'h04, 32'd1);
    step(); chk_intr("A_rearm", 1'b1);
    // Auto-reload, second expiry while unacknowledged sets pending.
    do_reset();
    wr(32'h04, 32'd2);
    wr(32'h00, 32'h7);
    step(); peek(32'h08, 32'd1, "B_cnt1");
    step(); peek(32'h08, 32'd0, "B_cnt0"); chk_intr("B_intr1", 1'b1);
    step(); peek(32'h08, 32'd2, "B_reload");
    step();
    step(); peek(32'h08, 32'd0, "B_cnt0b");
    wr(32'h00, 32'h0);
    chk_intr("B_ie_clear_keeps", 1'b1);
    inta = 1'b1;
    step(); chk_intr("B_ack", 1'b0);
    inta = 1'b0;
    step(); chk_intr("B_release", 1'b0);
    step(); chk_intr("B_pend_reassert", 1'b1);
    inta = 1'b1;
    step(); chk_intr("B_ack2", 1'b0);
    inta = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); chk_intr($sformatf("B_once%0d", i), 1'b0);
    end
    // Expiry beats a same-edge write-1-to-clear.
    do_reset();
    wr(32'h04, 32'd2);
    wr(32'h00, 32'h1);
    step();
    wr(32'h0C, 32'h1);
    peek(32'h0C, 32'd1, "C_exp_wins");
    chk_intr("C_no_ie", 1'b0);
    wr(32'h0C, 32'h1);
    peek(32'h0C, 32'd0, "C_w1c");
    peek(32'h08, 32'd0, "C_hold0");
    // Asynchronous reset while intr is asserted.
    do_reset();
    wr(32'h04, 32'd1);
    wr(32'h00, 32'h5);
    step(); chk_intr("D_intr", 1'b1);
    #2 reset = 1'b0;
    #1 chk_intr("D_async_drop", 1'b0);
    peek(32'h00, 32'h0, "D_ctrl");
    peek(32'h04, 32'h0, "D_load");
    peek(32'h08, 32'h0, "D_count");
    peek(32'h0C, 32'h0, "D_status");
    step();
    reset = 1'b1;
    inta = 1'b1;
    step(); step(); chk_intr("D_inta_ignored", 1'b0);
    inta = 1'b0;
`ifdef IO_TIMER_PRESCALE_EN
    do_reset();
    wr(32'h10, 32'd3);
    wr(32'h04, 32'd2);
    wr(32'h00, 32'h1);
    step(); step(); step(); peek(32'h08, 32'd2, "P_cyc3");
    step(); peek(32'h08, 32'd1, "P_cyc4");
    step(); step(); step(); peek(32'h08, 32'd1, "P_cyc7"); peek(32'h0C, 32'd0, "P_noexp");
    step(); peek(32'h08, 32'd0, "P_cyc8"); peek(32'h0C, 32'd1, "P_exp");
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
